// File: rtl/tick_timer_if.sv
// Control and status bundle for one tick_timer instance.
// The master drives the control pulses and period, and the slave (the timer) returns count and status.

interface tick_timer_if #(
  parameter int WIDTH = 25
);
  // There is no valid/ready pair here. Each control is sampled at every rising clk edge.
  // start, stop and load are single-cycle pulses: holding one high repeats its action every edge.
  // oneshot and clk_en are levels.
  logic             clk_en;
  logic             start;
  logic             stop;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic [WIDTH-1:0] count_val;
  logic             tick;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output clk_en, start, stop, load, load_val, oneshot,
    input  count_val, tick, busy, done, state_dbg
  );

  modport slave (
    input  clk_en, start, stop, load, load_val, oneshot,
    output count_val, tick, busy, done, state_dbg
  );
endinterface

// File: rtl/tick_timer.sv
// Down-counting tick generator with a loadable period, one-shot/periodic mode and start/stop.
// Emits a registered 1-cycle tick every period_q+1 enabled cycles.

module tick_timer #(
  parameter int                WIDTH          = 25,
  parameter logic [WIDTH-1:0]  DEFAULT_PERIOD = WIDTH'(9),
  parameter bit                AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  tick_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t RESET_STATE = AUTO_START ? RUN : IDLE;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] start_period;
  logic             terminal;

  // A start in the same cycle as a load must count from the new value.
  assign start_period = bus.load ? bus.load_val : period_q;
  assign terminal     = (state_q == RUN) && bus.clk_en && (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RESET_STATE;
      period_q <= DEFAULT_PERIOD;
      count_q  <= DEFAULT_PERIOD;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = bus.load ? bus.load_val : period_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    done_d   = done_q;

    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.start) begin
      state_d = RUN;
      count_d = start_period;
      done_d  = 1'b0;
    end else if (terminal) begin
      tick_d = 1'b1;
      if (bus.oneshot) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        // A load landing on this edge only takes effect from the next period.
        count_d = period_q;
      end
    end else if ((state_q == RUN) && bus.clk_en) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  assign bus.count_val = count_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed bench for tick_timer (WIDTH=25, DEFAULT_PERIOD=9, AUTO_START=1).
// Inputs change 1 ns after each rising edge, and outputs are checked at that same point.

module tb_tick_timer;
  localparam int WIDTH = 25;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  tick_timer_if #(.WIDTH(WIDTH)) bus ();

  tick_timer #(
    .WIDTH          (WIDTH),
    .DEFAULT_PERIOD (WIDTH'(9)),
    .AUTO_START     (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int cnt, input bit tk, input bit bsy, input bit dn);
    check({tag, ".count"}, 32'(bus.count_val), 32'(cnt));
    check({tag, ".tick"},  32'(bus.tick),      32'(tk));
    check({tag, ".busy"},  32'(bus.busy),      32'(bsy));
    check({tag, ".done"},  32'(bus.done),      32'(dn));
  endtask

  initial begin
    int e;
    int m;
    reset        = 1'b1;
    bus.clk_en   = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.oneshot  = 1'b0;

    // Reset state
    cyc();
    check_all("reset", 9, 1'b0, 1'b1, 1'b0);
    check("reset.state", 32'(bus.state_dbg), 32'd1);
    cyc();
    reset = 1'b0;

    // 1: free-running period 10
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check_all("run10", (k % 10 == 0) ? 9 : 9 - (k % 10), (k % 10 == 0), 1'b1, 1'b0);
    end

    // 2: clk_en toggling, tick every 20 clocks
    for (int k = 1; k <= 40; k++) begin
      bus.clk_en = (k % 2 == 1);
      cyc();
      e = (k + 1) / 2;
      check_all("clken", (e % 10 == 0) ? 9 : 9 - (e % 10), (k % 2 == 1) && (e % 10 == 0), 1'b1, 1'b0);
    end
    bus.clk_en = 1'b1;

    // 3: load mid-count, old run finishes, then period 4
    for (int k = 0; k < 4; k++) cyc();
    check("pre_load.count", 32'(bus.count_val), 32'd5);
    bus.load = 1'b1; bus.load_val = WIDTH'(3);
    cyc();
    bus.load = 1'b0;
    check("load.count", 32'(bus.count_val), 32'd4);
    for (int j = 1; j <= 12; j++) begin
      cyc();
      if (j <= 4) begin
        check_all("drain", 4 - j, 1'b0, 1'b1, 1'b0);
      end else begin
        m = (j - 5) % 4;
        check_all("run4", 3 - m, (m == 0), 1'b1, 1'b0);
      end
    end

    // 4: one-shot with load+start same cycle
    bus.oneshot = 1'b1; bus.start = 1'b1; bus.load = 1'b1; bus.load_val = WIDTH'(2);
    cyc();
    bus.start = 1'b0; bus.load = 1'b0;
    check_all("os_start", 2, 1'b0, 1'b1, 1'b0);
    cyc(); check_all("os_1", 1, 1'b0, 1'b1, 1'b0);
    cyc(); check_all("os_0", 0, 1'b0, 1'b1, 1'b0);
    cyc(); check_all("os_term", 0, 1'b1, 1'b0, 1'b1);
    check("os_term.state", 32'(bus.state_dbg), 32'd2);
    cyc(); check_all("os_hold", 0, 1'b0, 1'b0, 1'b1);
    cyc(); check_all("os_hold2", 0, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_all("os_restart", 2, 1'b0, 1'b1, 1'b0);

    // 5: stop at 5, start+stop keeps IDLE, start alone reloads 9
    bus.oneshot = 1'b0; bus.load = 1'b1; bus.load_val = WIDTH'(9); bus.start = 1'b1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
    check_all("p9_start", 9, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc();
    check("pre_stop.count", 32'(bus.count_val), 32'd5);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_all("stop", 5, 1'b0, 1'b0, 1'b0);
    check("stop.state", 32'(bus.state_dbg), 32'd0);
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    check_all("start_stop", 5, 1'b0, 1'b0, 1'b0);
    cyc(); cyc();
    check_all("idle_hold", 5, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check_all("restart", 9, 1'b0, 1'b1, 1'b0);
    cyc(); check_all("restart_dec", 8, 1'b0, 1'b1, 1'b0);

    // 6: period 0 ticks every enabled cycle, reset mid-run
    bus.load = 1'b1; bus.load_val = '0; bus.start = 1'b1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
    check_all("p0_start", 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(); check_all("p0_tick", 0, 1'b1, 1'b1, 1'b0);
    end
    bus.clk_en = 1'b0;
    cyc(); check_all("p0_gated", 0, 1'b0, 1'b1, 1'b0);
    bus.clk_en = 1'b1;
    cyc(); check_all("p0_tick2", 0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    cyc();
    check_all("mid_reset", 9, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    cyc(); check_all("post_reset", 8, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
